// File: rtl/spi2adc_if.sv
`timescale 1ns/1ps
// SPI2ADC bus: the conversion request/result handshake towards the user
// logic plus the four-wire SPI link to an MCP3002-style ADC.
interface spi2adc_if;
    logic       start;
    logic       channel;
    logic [9:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       ADC_CS;
    logic       ADC_SCK;
    logic       ADC_SDO;
    logic       ADC_SDI;

    // The controller side: takes requests and ADC data, drives the SPI pins.
    modport master (
        input  start, channel, ADC_SDI,
        output data_out, data_valid, busy, ADC_CS, ADC_SCK, ADC_SDO
    );

    // The user/ADC side: issues requests, returns ADC data.
    modport slave (
        output start, channel, ADC_SDI,
        input  data_out, data_valid, busy, ADC_CS, ADC_SCK, ADC_SDO
    );
endinterface

// File: rtl/spi2adc.sv
`timescale 1ns/1ps
// SPI2ADC: runs one 16-SCK single-ended conversion on an MCP3002-style ADC
// per accepted start and presents the 10-bit result with a one-cycle strobe.
// Every SPI output is decoded from the state and the half-period counters,
// so SCK edges line up exactly with CLOCK_50 cycle boundaries.
module spi2adc #(
    parameter int HALF_PERIOD = 25
) (
    input logic       CLOCK_50,
    input logic       reset,
    spi2adc_if.master bus
);

    localparam int            CW   = $clog2(HALF_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, RECOVER} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] half_cnt;
    logic [3:0]    bit_cnt;
    logic          sck_high;
    logic          chan_q;
    logic [9:0]    shift_q;
    logic [9:0]    data_q;
    logic          half_done;
    logic [4:0]    sdo_idx;

    assign half_done = (half_cnt == LAST);

    // While SCK is high the ADC samples command bit k; during the low half
    // the next command bit is already presented.
    assign sdo_idx = sck_high ? {1'b0, bit_cnt} : ({1'b0, bit_cnt} + 5'd1);

    // Command word: start, single-ended, channel, MSB-first, then zeros.
    function automatic logic cmd_bit(input logic [4:0] idx, input logic ch);
        case (idx)
            5'd0, 5'd1, 5'd3: cmd_bit = 1'b1;
            5'd2:             cmd_bit = ch;
            default:          cmd_bit = 1'b0;
        endcase
    endfunction

    // State register; reset always wins over a pending start.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: SHIFT hands over to RECOVER as the 16th SCK high half ends,
    // so the last SCK low half is spent with CS already released.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = SETUP;
            SETUP:   if (half_done) next_state = SHIFT;
            SHIFT:   if (half_done && sck_high && (bit_cnt == 4'd15)) next_state = RECOVER;
            RECOVER: if (half_done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Timing counters, channel latch, ADC data capture and result register.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            sck_high <= 1'b0;
            chan_q   <= 1'b0;
            shift_q  <= '0;
            data_q   <= '0;
        end else begin
            if ((state == IDLE) || half_done) begin
                half_cnt <= '0;
            end else begin
                half_cnt <= half_cnt + CW'(1);
            end

            if ((state == IDLE) && bus.start) begin
                chan_q <= bus.channel;
            end

            if (state == SETUP) begin
                sck_high <= 1'b1;
                bit_cnt  <= '0;
            end else if ((state == SHIFT) && half_done) begin
                sck_high <= ~sck_high;
                if (!sck_high) begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end

            if ((state == SHIFT) && sck_high && (half_cnt == '0) &&
                (bit_cnt >= 4'd5) && (bit_cnt <= 4'd14)) begin
                shift_q <= {shift_q[8:0], bus.ADC_SDI};
            end

            if ((state == SHIFT) && (next_state == RECOVER)) begin
                data_q <= shift_q;
            end
        end
    end

    // Moore outputs decoded from state and counters.
    always_comb begin
        bus.ADC_CS     = 1'b1;
        bus.ADC_SCK    = 1'b0;
        bus.ADC_SDO    = 1'b0;
        bus.busy       = 1'b1;
        bus.data_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
            end
            SETUP: begin
                bus.ADC_CS  = 1'b0;
                bus.ADC_SDO = 1'b1;
            end
            SHIFT: begin
                bus.ADC_CS  = 1'b0;
                bus.ADC_SCK = sck_high;
                bus.ADC_SDO = cmd_bit(sdo_idx, chan_q);
            end
            RECOVER: begin
                bus.data_valid = (half_cnt == '0);
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

    assign bus.data_out = data_q;

endmodule

// File: tb/tb_spi2adc.sv
`timescale 1ns/1ps
// Testbench for spi2adc: two instances (HALF_PERIOD 25 and 2), each talking
// to a behavioural MCP3002-style ADC that returns queued 10-bit results.
module tb_spi2adc;

    localparam int H   = 25;
    localparam int H2  = 2;
    localparam int PER = 33 * H + 1;

    logic CLOCK_50 = 1'b0;
    logic reset;
    int   edge_cnt   = 0;
    int   compared   = 0;
    int   mismatched = 0;

    spi2adc_if bus25 ();
    spi2adc_if bus2 ();

    spi2adc #(.HALF_PERIOD(H))  dut25 (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus25));
    spi2adc #(.HALF_PERIOD(H2)) dut2  (.CLOCK_50(CLOCK_50), .reset(reset), .bus(bus2));

    // 50 MHz system clock and an edge counter used as the time base.
    always #10 CLOCK_50 = ~CLOCK_50;
    always @(posedge CLOCK_50) edge_cnt <= edge_cnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        #1;
    endtask

    // ADC model result bit for SCK period k: null bit at k=4, data MSB-first k=5..14.
    function automatic logic adcBit(input logic [9:0] val, input int k);
        if ((k >= 5) && (k <= 14)) return val[14 - k];
        return 1'b0;
    endfunction

    // ---------------- ADC model for the H=25 instance ----------------
    logic [9:0] res_q25[$];
    logic [9:0] cur25  = '0;
    int         fall25 = 0;
    logic       sdi25  = 1'b0;
    logic       din25[$];
    assign bus25.ADC_SDI = sdi25;

    always @(negedge bus25.ADC_CS) begin
        if (res_q25.size() > 0) cur25 = res_q25.pop_front();
        else cur25 = '0;
        fall25 = 0;
        sdi25  = 1'b0;
        din25.delete();
    end
    always @(posedge bus25.ADC_SCK) if (!bus25.ADC_CS) din25.push_back(bus25.ADC_SDO);
    always @(negedge bus25.ADC_SCK) begin
        if (!bus25.ADC_CS) begin
            fall25++;
            sdi25 = adcBit(cur25, fall25);
        end
    end

    // ---------------- ADC model for the H=2 instance ----------------
    logic [9:0] res_q2[$];
    logic [9:0] cur2  = '0;
    int         fall2 = 0;
    logic       sdi2  = 1'b0;
    logic       din2[$];
    assign bus2.ADC_SDI = sdi2;

    always @(negedge bus2.ADC_CS) begin
        if (res_q2.size() > 0) cur2 = res_q2.pop_front();
        else cur2 = '0;
        fall2 = 0;
        sdi2  = 1'b0;
        din2.delete();
    end
    always @(posedge bus2.ADC_SCK) if (!bus2.ADC_CS) din2.push_back(bus2.ADC_SDO);
    always @(negedge bus2.ADC_SCK) begin
        if (!bus2.ADC_CS) begin
            fall2++;
            sdi2 = adcBit(cur2, fall2);
        end
    end

    assert property (@(posedge CLOCK_50) $rose(bus2.ADC_SCK) |-> $stable(bus2.ADC_SDO))
        else $error("[TB] FAIL h2_sdo_assert: ADC_SDO moved as ADC_SCK rose");

    // ---------------- Monitors ----------------
    int         dv_edge25[$];
    logic [9:0] dv_data25[$];
    int         dv_edge2[$];
    logic [9:0] dv_data2[$];
    int         sck_rise2[$];
    logic       sck_prev25 = 1'b0, sdo_prev25 = 1'b0;
    logic       sck_prev2  = 1'b0, sdo_prev2  = 1'b0;

    always @(negedge CLOCK_50) begin
        if (bus25.data_valid) begin
            dv_edge25.push_back(edge_cnt);
            dv_data25.push_back(bus25.data_out);
        end
        if (bus2.data_valid) begin
            dv_edge2.push_back(edge_cnt);
            dv_data2.push_back(bus2.data_out);
        end
        if (!sck_prev25 && bus25.ADC_SCK)
            checkOutput("sdo_stable_sck_rise", bus25.ADC_SDO, sdo_prev25);
        if (!sck_prev2 && bus2.ADC_SCK) begin
            checkOutput("h2_sdo_stable_sck_rise", bus2.ADC_SDO, sdo_prev2);
            sck_rise2.push_back(edge_cnt);
        end
        sck_prev25 = bus25.ADC_SCK;
        sdo_prev25 = bus25.ADC_SDO;
        sck_prev2  = bus2.ADC_SCK;
        sdo_prev2  = bus2.ADC_SDO;
    end

    // Wait for idle, then present start for the H=25 instance; acc is the
    // edge that samples it (cycle 0 of the transaction ends there).
    task automatic applyStimulus(input logic ch, input logic hold, output int acc);
        int guard = 0;
        while (bus25.busy && (guard < 40 * H)) begin
            tick();
            guard++;
        end
        checkOutput("idle_before_start", bus25.busy, 0);
        bus25.start   = 1'b1;
        bus25.channel = ch;
        acc = edge_cnt + 1;
        if (!hold) begin
            tick();
            bus25.start   = 1'b0;
            bus25.channel = 1'($urandom_range(0, 1));
        end
    endtask

    // Reference timeline: data_valid in cycle 32H+1, busy through cycle 33H.
    task automatic expectConversion(input string tag, input int acc,
                                    input logic [9:0] exp_data, input logic exp_ch);
        int         waited = 0;
        logic [3:0] din_bits;
        while ((dv_edge25.size() == 0) && (waited < 34 * H)) begin
            tick();
            waited++;
        end
        checkOutput({tag, "_dv_count"}, dv_edge25.size(), 1);
        if (dv_edge25.size() == 0) return;
        checkOutput({tag, "_latency"}, dv_edge25[0] - acc + 1, 32 * H + 1);
        checkOutput({tag, "_data"}, dv_data25[0], exp_data);
        for (int i = 0; i < 4; i++)
            din_bits[3 - i] = (i < din25.size()) ? din25[i] : 1'bx;
        checkOutput({tag, "_din_k0_k3"}, din_bits, {1'b1, 1'b1, exp_ch, 1'b1});
        tick();
        checkOutput({tag, "_dv_width"}, bus25.data_valid, 0);
        while ((edge_cnt - acc + 1) < 33 * H) tick();
        checkOutput({tag, "_busy_last"}, bus25.busy, 1);
        tick();
        checkOutput({tag, "_busy_drop"}, bus25.busy, 0);
        checkOutput({tag, "_data_hold"}, bus25.data_out, exp_data);
        dv_edge25.delete();
        dv_data25.delete();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int         acc;
        int         n;
        int         m;
        int         loc;
        int         dv_n[$];
        int         cs_cnt[0:2];
        logic       ch;
        logic [9:0] val;
        logic [9:0] vals[0:2];

        reset = 1'b1;
        bus25.start = 1'b0; bus25.channel = 1'b0;
        bus2.start  = 1'b0; bus2.channel  = 1'b0;
        repeat (3) tick();
        checkOutput("rst_cs",   bus25.ADC_CS, 1);
        checkOutput("rst_sck",  bus25.ADC_SCK, 0);
        checkOutput("rst_sdo",  bus25.ADC_SDO, 0);
        checkOutput("rst_busy", bus25.busy, 0);
        checkOutput("rst_dv",   bus25.data_valid, 0);
        checkOutput("rst_data", bus25.data_out, 0);
        reset = 1'b0;
        tick();

        $display("[TB] channel 0, result 0x2A5");
        res_q25.push_back(10'h2A5);
        applyStimulus(1'b0, 1'b0, acc);
        expectConversion("ch0_2a5", acc, 10'h2A5, 1'b0);

        $display("[TB] channel 1, results 0x3FF then 0x000");
        res_q25.push_back(10'h3FF);
        res_q25.push_back(10'h000);
        applyStimulus(1'b1, 1'b0, acc);
        expectConversion("ch1_3ff", acc, 10'h3FF, 1'b1);
        applyStimulus(1'b1, 1'b0, acc);
        expectConversion("ch1_000", acc, 10'h000, 1'b1);

        $display("[TB] randomized conversions");
        for (int i = 0; i < 4; i++) begin
            val = 10'($urandom_range(0, 1023));
            ch  = 1'($urandom_range(0, 1));
            res_q25.push_back(val);
            applyStimulus(ch, 1'b0, acc);
            expectConversion("rand", acc, val, ch);
        end

        $display("[TB] start held high for three conversions");
        for (int i = 0; i < 3; i++) begin
            vals[i]   = 10'($urandom_range(0, 1023));
            cs_cnt[i] = 0;
            res_q25.push_back(vals[i]);
        end
        applyStimulus(1'b0, 1'b1, acc);
        while ((edge_cnt - acc + 1) < 2 * PER + 32 * H + 1) begin
            tick();
            n   = edge_cnt - acc + 1;
            m   = (n - 1) / PER;
            loc = n - m * PER;
            if (bus25.data_valid) dv_n.push_back(n);
            if ((loc >= 32 * H + 1) && (loc <= 33 * H) && bus25.ADC_CS && (m <= 2)) cs_cnt[m]++;
            if ((m >= 1) && (loc == 1)) checkOutput("held_cs_low_again", bus25.ADC_CS, 0);
        end
        bus25.start = 1'b0;
        checkOutput("held_dv_count", dv_n.size(), 3);
        for (int i = 0; i < 3; i++) begin
            checkOutput("held_dv_cycle", (i < dv_n.size()) ? dv_n[i] : -1, 32 * H + 1 + i * PER);
            checkOutput("held_data", (i < dv_data25.size()) ? 32'(dv_data25[i]) : 32'hFFFF, 32'(vals[i]));
        end
        checkOutput("held_cs_recover_0", cs_cnt[0], H);
        checkOutput("held_cs_recover_1", cs_cnt[1], H);
        while ((edge_cnt - acc + 1) < 3 * PER) tick();
        checkOutput("held_busy_drop", bus25.busy, 0);
        tick();
        checkOutput("held_no_fourth", bus25.busy, 0);
        dv_edge25.delete();
        dv_data25.delete();

        $display("[TB] start pulse during SHIFT is ignored");
        val = 10'($urandom_range(0, 1023));
        ch  = 1'($urandom_range(0, 1));
        res_q25.push_back(val);
        res_q25.push_back(10'h155);
        applyStimulus(ch, 1'b0, acc);
        while ((edge_cnt - acc + 1) < H + 10) tick();
        bus25.start   = 1'b1;
        bus25.channel = ~ch;
        tick();
        bus25.start   = 1'b0;
        expectConversion("midshift", acc, val, ch);
        repeat (3) tick();
        checkOutput("midshift_no_queue", bus25.busy, 0);
        checkOutput("midshift_no_extra_dv", dv_edge25.size(), 0);
        void'(res_q25.pop_front());

        $display("[TB] reset in the middle of SHIFT");
        val = 10'($urandom_range(1, 1023));
        res_q25.push_back(10'h3C3);
        res_q25.push_back(val);
        applyStimulus(1'b1, 1'b0, acc);
        while ((edge_cnt - acc + 1) < 400) tick();
        reset = 1'b1;
        tick();
        checkOutput("abort_cs",   bus25.ADC_CS, 1);
        checkOutput("abort_busy", bus25.busy, 0);
        checkOutput("abort_dv",   bus25.data_valid, 0);
        checkOutput("abort_data", bus25.data_out, 0);
        checkOutput("abort_no_dv_seen", dv_edge25.size(), 0);
        reset         = 1'b0;
        ch            = 1'($urandom_range(0, 1));
        bus25.start   = 1'b1;
        bus25.channel = ch;
        acc = edge_cnt + 1;
        tick();
        bus25.start = 1'b0;
        expectConversion("after_reset", acc, val, ch);

        $display("[TB] reset has priority over start");
        reset       = 1'b1;
        bus25.start = 1'b1;
        tick();
        checkOutput("prio_busy", bus25.busy, 0);
        checkOutput("prio_cs",   bus25.ADC_CS, 1);
        reset       = 1'b0;
        bus25.start = 1'b0;
        tick();
        checkOutput("prio_still_idle", bus25.busy, 0);

        $display("[TB] HALF_PERIOD=2 instance");
        val = 10'($urandom_range(0, 1023));
        ch  = 1'($urandom_range(0, 1));
        res_q2.push_back(val);
        sck_rise2.delete();
        bus2.start   = 1'b1;
        bus2.channel = ch;
        acc = edge_cnt + 1;
        tick();
        bus2.start   = 1'b0;
        bus2.channel = ~ch;
        n = 0;
        while ((dv_edge2.size() == 0) && (n < 200)) begin
            tick();
            n++;
        end
        checkOutput("h2_dv_count", dv_edge2.size(), 1);
        if (dv_edge2.size() > 0) begin
            checkOutput("h2_latency", dv_edge2[0] - acc + 1, 32 * H2 + 1);
            checkOutput("h2_data", dv_data2[0], val);
        end
        checkOutput("h2_sck_rises", sck_rise2.size(), 16);
        if (sck_rise2.size() >= 2) begin
            checkOutput("h2_first_rise", sck_rise2[0] - acc + 1, H2 + 1);
            checkOutput("h2_sck_period", sck_rise2[1] - sck_rise2[0], 2 * H2);
        end
        checkOutput("h2_din_k2", (din2.size() > 2) ? din2[2] : 1'bx, ch);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/spi2adc.md
SPI2ADC -- requirements
Module: spi2adc

Interface
REQ-001 Parameter HALF_PERIOD, default 25, SHALL set the CLOCK_50 cycles per SCK half-period (1 MHz SCK at 50 MHz); legal values are 2 or more.
REQ-002 CLOCK_50  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  conversion request, sampled only while busy=0.
REQ-005 channel  input  1  ADC channel select (0 = CH0, 1 = CH1), latched on an accepted start.
REQ-006 ADC_SDI  input  1  serial data from ADC DOUT.
REQ-007 ADC_CS  output  1  ADC chip select, active-low.
REQ-008 ADC_SCK  output  1  serial clock, idle low.
REQ-009 ADC_SDO  output  1  serial data to ADC DIN.
REQ-010 data_out  output  10  last completed conversion result.
REQ-011 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-012 busy  output  1  high while a transaction or its CS recovery is in progress.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, SHIFT and RECOVER; with H = HALF_PERIOD and cycle 0 = the cycle start=1 is sampled in IDLE:
- IDLE: ADC_CS=1, ADC_SCK=0, ADC_SDO=0, busy=0.
- SETUP: cycles 1..H; ADC_CS=0, ADC_SCK=0, ADC_SDO=1 (start bit).
- SHIFT: 16 SCK periods, k=0..15; SCK high on cycles H+1+2Hk .. 2H+2Hk, low for the next H cycles.
- RECOVER: cycles 32H+1..33H; ADC_CS=1, ADC_SCK=0.
- IDLE again at cycle 33H+1, where start is accepted.
REQ-014 ADC_SDO SHALL carry, for k=0..3, the bits 1 (start), 1 (single-ended), channel, 1 (MSB-first); ADC_SDO SHALL change only on cycles where SCK falls (or on SETUP entry) and SHALL be 0 for k>=4.
REQ-015 ADC_SDI SHALL be sampled on the cycle SCK goes high, for k=5..14 only, shifted MSB-first into a 10-bit register; k=4 (null bit) and k=15 SHALL be ignored.
REQ-016 At cycle 32H+1, data_out SHALL load the shift register and data_valid SHALL be 1 for exactly that cycle.
REQ-017 data_out SHALL hold its value between conversions and SHALL NOT change during SHIFT.
REQ-018 busy SHALL be 1 from cycle 1 through cycle 33H inclusive.
REQ-019 start and channel changes while busy=1 SHALL be ignored; there is no queueing.
REQ-020 A start held high continuously SHALL cause back-to-back conversions with period 33H+1 cycles.
REQ-021 The channel used for a transaction SHALL be the value sampled at cycle 0, even if channel changes later.
REQ-022 Start-to-data_valid latency SHALL be exactly 32H+1 cycles (801 at the default).

Reset
REQ-023 With reset=1 at a rising edge, the next state SHALL be IDLE with ADC_CS=1, ADC_SCK=0, ADC_SDO=0, busy=0, data_valid=0 and data_out=0.
REQ-024 Reset SHALL take priority over start in the same cycle.
REQ-025 Reset mid-SHIFT SHALL abort the transaction with no data_valid pulse; a start in the first cycle after reset is released SHALL be accepted.

Verification
REQ-026 Bench SHALL use a behavioural MCP3002-style ADC model that drives DOUT on SCK falling edges.
REQ-027 H=25, channel=0, model returns 10'h2A5: start pulse -> data_valid at cycle 801, data_out=10'h2A5, ADC_SDO bits k0..k3 = 1,1,0,1.
REQ-028 channel=1, model returns 10'h3FF then 10'h000 on consecutive conversions -> data_out 10'h3FF then 10'h000; k2 bit = 1.
REQ-029 start held high for 3 conversions -> data_valid at cycles 801, 1627, 2453; ADC_CS high for exactly 25 cycles between transactions.
REQ-030 Start pulse at cycle 10 of SHIFT -> ignored; a single data_valid at cycle 801 only.
REQ-031 Reset asserted at cycle 400 -> ADC_CS=1 and busy=0 on the next cycle, no data_valid, data_out=0.
REQ-032 H=2: SCK period 4 cycles, data_valid at cycle 65, correct data; an assertion SHALL check ADC_SDO is stable whenever SCK rises.
